// File: rtl/spim_pkg.sv
// spim_pkg: FSM states, R/W encoding and frame-length helpers shared by spi_master_ctrl.
package spim_pkg;
    typedef enum logic [2:0] {IDLE, SHIFT_LO, SHIFT_HI, TAIL, GAP} state_t;
    localparam logic RW_READ = 1'b1;
    localparam logic RW_WRITE = 1'b0;
    localparam int ADDR_W = 7;
    localparam int DATA_W = 8;
    localparam int FRAME_BITS = ADDR_W + 1 + DATA_W;
    function automatic int frame_bits(input int aw, input int dw);
        return aw + 1 + dw;
    endfunction
endpackage

// File: rtl/spi_master_ctrl_if.sv
// spi_master_ctrl_if: request/response bus between system logic and spi_master_ctrl.
interface spi_master_ctrl_if #(parameter int ADDR_W = 7, parameter int DATA_W = 8);
    logic req_valid, req_ready, req_rw, rsp_valid, busy;
    logic [ADDR_W-1:0] req_addr;
    logic [DATA_W-1:0] req_wdata, rsp_rdata;
    modport master (output req_valid, req_rw, req_addr, req_wdata,
                    input req_ready, rsp_valid, rsp_rdata, busy);
    modport slave (input req_valid, req_rw, req_addr, req_wdata,
                   output req_ready, rsp_valid, rsp_rdata, busy);
endinterface

// File: rtl/spim_clkgen.sv
// spim_clkgen: SCLK half-period counter, strobes half_tick on the last clk of each half-period.
module spim_clkgen #(parameter int CLKDIV = 4) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear,
    input  logic run,
    output logic half_tick
);
    localparam int CW = $clog2(CLKDIV);
    logic [CW-1:0] cnt;
    assign half_tick = run && cnt == CW'(CLKDIV - 1);
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) cnt <= '0;
        else cnt <= (clear || half_tick || !run) ? '0 : cnt + 1'b1;
endmodule

// File: rtl/spi_master_ctrl.sv
// spi_master_ctrl: turns valid/ready requests into {addr, rw, data} SPI frames for spimemory.
// Defining SPIM_CS_GAP_EN adds a GAP state holding cs_pin high for CS_GAP cycles after each frame.
module spi_master_ctrl
    import spim_pkg::*;
#(
    parameter int CLKDIV = 4,
    parameter int ADDR_W = 7,
    parameter int DATA_W = 8,
    parameter int CS_GAP = 4
) (
    input  logic clk,
    input  logic rst_n,
    spi_master_ctrl_if.slave bus,
    output logic sclk_pin,
    output logic cs_pin,
    output logic mosi_pin,
    input  logic miso_pin
);
    localparam int FB = frame_bits(ADDR_W, DATA_W);
    localparam int BW = $clog2(FB);
    if (CLKDIV < 2 || CS_GAP < 1) $error("spi_master_ctrl: CLKDIV must be >= 2 and CS_GAP >= 1");
    state_t state, state_n;
    logic [FB-1:0] sh;
    logic [BW-1:0] bit_cnt;
    logic [DATA_W-1:0] rx;
    logic rw, half_tick, accept, in_frame, last_bit, frame_end, gap_done;
    assign accept = bus.req_valid && state == IDLE;
    assign in_frame = state inside {SHIFT_LO, SHIFT_HI, TAIL};
    assign last_bit = bit_cnt == BW'(FB - 1);
    assign frame_end = state == TAIL && half_tick;
`ifdef SPIM_CS_GAP_EN
    localparam state_t AFTER = GAP;
    localparam int GW = $clog2(CS_GAP + 1);
    logic [GW-1:0] gap_cnt;
    assign gap_done = gap_cnt == GW'(CS_GAP - 1);
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) gap_cnt <= '0;
        else gap_cnt <= state == GAP ? gap_cnt + 1'b1 : '0;
`else
    localparam state_t AFTER = IDLE;
    assign gap_done = 1'b1;
`endif
    spim_clkgen #(.CLKDIV(CLKDIV)) u_clkgen (
        .clk(clk), .rst_n(rst_n), .clear(accept), .run(in_frame), .half_tick(half_tick)
    );
    always_comb begin
        state_n = state;
        bus.req_ready = state == IDLE;
        bus.busy = state != IDLE;
        cs_pin = !in_frame;
        sclk_pin = state == SHIFT_HI;
        mosi_pin = state inside {SHIFT_LO, SHIFT_HI} && sh[FB-1];
        case (state)
            IDLE:     state_n = accept ? SHIFT_LO : IDLE;
            SHIFT_LO: state_n = half_tick ? SHIFT_HI : SHIFT_LO;
            SHIFT_HI: state_n = half_tick ? (last_bit ? TAIL : SHIFT_LO) : SHIFT_HI;
            TAIL:     state_n = half_tick ? AFTER : TAIL;
            GAP:      state_n = gap_done ? IDLE : GAP;
            default:  state_n = IDLE;
        endcase
    end
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            state <= IDLE;
            sh <= '0;
            bit_cnt <= '0;
            rx <= '0;
            rw <= RW_WRITE;
            bus.rsp_valid <= 1'b0;
            bus.rsp_rdata <= '0;
        end else begin
            state <= state_n;
            bus.rsp_valid <= frame_end;
            if (accept) begin
                sh <= {bus.req_addr, bus.req_rw, bus.req_wdata & {DATA_W{bus.req_rw == RW_WRITE}}};
                rw <= bus.req_rw;
                bit_cnt <= '0;
            end else if (state == SHIFT_HI && half_tick) begin
                sh <= sh << 1;
                bit_cnt <= bit_cnt + 1'b1;
                if (rw == RW_READ && bit_cnt >= BW'(ADDR_W + 1)) rx <= {rx[DATA_W-2:0], miso_pin};
            end
            if (frame_end && rw == RW_READ) bus.rsp_rdata <= rx;
        end
endmodule

// File: tb/tb_spi_master_ctrl.sv
// tb_spi_master_ctrl: scoreboard bench with SPI memory models on a CLKDIV=4 and a CLKDIV=2 controller.
module tb_spi_master_ctrl;
    typedef struct {
        logic [7:0]  rdata;
        logic [15:0] frame;
        int          acc;
        int          lat;
    } exp_t;
`ifdef SPIM_CS_GAP_EN
    localparam int EXP_GAP = 5;
`else
    localparam int EXP_GAP = 1;
`endif
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic [1:0] sclk, cs, mosi, miso;
    int cyc = 0, checks = 0, errors = 0;
    int acc0 = 0, rsp0 = 0;
    int hi_run = 0, lo_run = 0, last_hi = 0, last_lo = 0;
    logic [7:0] last_rd [2] = '{8'h00, 8'h00};
    exp_t q0 [$];
    exp_t q1 [$];

    spi_master_ctrl_if b0 ();
    spi_master_ctrl_if b1 ();
    spi_master_ctrl #(.CLKDIV(4)) dut0 (
        .clk(clk), .rst_n(rst_n), .bus(b0),
        .sclk_pin(sclk[0]), .cs_pin(cs[0]), .mosi_pin(mosi[0]), .miso_pin(miso[0])
    );
    spi_master_ctrl #(.CLKDIV(2)) dut1 (
        .clk(clk), .rst_n(rst_n), .bus(b1),
        .sclk_pin(sclk[1]), .cs_pin(cs[1]), .mosi_pin(mosi[1]), .miso_pin(miso[1])
    );

    initial forever #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Mode-0 memory: sample MOSI on rising SCLK, present read data from the falling edge after R/W.
    for (genvar g = 0; g < 2; g++) begin : sl
        logic [15:0] sh = '0, last = '0;
        logic [7:0] mem [128];
        logic [7:0] rd = '0;
        logic so = 1'b0;
        int n = 0;
        assign miso[g] = so;
        initial for (int i = 0; i < 128; i++) mem[i] = 8'h00;
        always @(posedge sclk[g] or posedge cs[g])
            if (cs[g]) n <= 0;
            else begin
                sh <= {sh[14:0], mosi[g]};
                n <= n + 1;
                if (n == 15) begin
                    last <= {sh[14:0], mosi[g]};
                    if (!sh[7]) mem[sh[14:8]] <= {sh[6:0], mosi[g]};
                end
            end
        always @(negedge sclk[g])
            if (!cs[g] && n >= 8 && n < 16) begin
                so <= n == 8 ? mem[sh[7:1]][7] : rd[7];
                rd <= n == 8 ? mem[sh[7:1]] << 1 : rd << 1;
            end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic drive(input int inst, input logic v, input logic rw, input logic [6:0] a, input logic [7:0] d);
        if (inst == 0) begin
            b0.req_valid = v; b0.req_rw = rw; b0.req_addr = a; b0.req_wdata = d;
        end else begin
            b1.req_valid = v; b1.req_rw = rw; b1.req_addr = a; b1.req_wdata = d;
        end
    endtask

    // Caller is at a negedge; returns at the negedge after the accept edge with req_valid still high.
    task automatic send(input int inst, input logic rw, input logic [6:0] a, input logic [7:0] d,
                        input logic [15:0] frame, input logic [7:0] rexp);
        exp_t e;
        drive(inst, 1'b1, rw, a, d);
        for (int t = 0; t < 1000; t++) begin
            if (inst == 0 ? b0.req_ready : b1.req_ready) begin
                if (rw) last_rd[inst] = rexp;
                e.rdata = last_rd[inst];
                e.frame = frame;
                e.acc = cyc;
                e.lat = inst == 0 ? 133 : 67;
                if (inst == 0) q0.push_back(e); else q1.push_back(e);
                @(negedge clk);
                return;
            end
            @(negedge clk);
        end
        chk("accept_timeout", 0, 1);
    endtask

    task automatic drain();
        for (int t = 0; t < 2000 && (q0.size() + q1.size()) != 0; t++) @(negedge clk);
        chk("drain_pending", q0.size() + q1.size(), 0);
        repeat (2) @(negedge clk);
    endtask

    task automatic check_rsp(input int inst, input logic [7:0] rd);
        exp_t e;
        chk("rsp_expected", (inst == 0 ? q0.size() : q1.size()) > 0, 1);
        if ((inst == 0 ? q0.size() : q1.size()) == 0) return;
        if (inst == 0) e = q0.pop_front(); else e = q1.pop_front();
        chk("latency", cyc - e.acc, e.lat);
        chk("mosi_frame", inst == 0 ? sl[0].last : sl[1].last, e.frame);
        chk("rsp_rdata", rd, e.rdata);
    endtask

    always @(posedge clk) if (rst_n && b0.req_valid && b0.req_ready) acc0++;

    always @(negedge clk)
        if (rst_n) begin
            if (b0.rsp_valid) begin
                rsp0++;
                check_rsp(0, b0.rsp_rdata);
            end
            if (b1.rsp_valid) check_rsp(1, b1.rsp_rdata);
        end

    always @(negedge clk)
        if (!rst_n) begin
            hi_run = 0; lo_run = 0;
        end else if (cs[0]) begin
            if (lo_run > 0) last_lo = lo_run;
            lo_run = 0; hi_run++;
        end else begin
            if (hi_run > 0) last_hi = hi_run;
            hi_run = 0; lo_run++;
        end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int s_acc, s_rsp;
        drive(0, 0, 0, 0, 0);
        drive(1, 0, 0, 0, 0);
        #1;
        chk("rst_cs", cs[0], 1);
        chk("rst_sclk", sclk[0], 0);
        chk("rst_mosi", mosi[0], 0);
        chk("rst_ready", b0.req_ready, 1);
        chk("rst_rsp_valid", b0.rsp_valid, 0);
        chk("rst_rdata", b0.rsp_rdata, 0);
        chk("rst_busy", b0.busy, 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        send(0, 0, 7'h03, 8'h55, 16'h0655, 8'h00);
        drive(0, 0, 0, 0, 0);
        drain();
        chk("cs_low_len", last_lo, 132);
        chk("mem3_written", sl[0].mem[3], 8'h55);
        send(0, 1, 7'h03, 8'h00, 16'h0700, 8'h55);
        drive(0, 0, 0, 0, 0);
        drain();
        send(0, 0, 7'h01, 8'hA5, 16'h02A5, 8'h00);
        send(0, 0, 7'h02, 8'h3C, 16'h043C, 8'h00);
        drive(0, 0, 0, 0, 0);
        drain();
        chk("cs_gap_b2b", last_hi, EXP_GAP);
        send(0, 1, 7'h01, 8'h00, 16'h0300, 8'hA5);
        send(0, 1, 7'h02, 8'h00, 16'h0500, 8'h3C);
        drive(0, 0, 0, 0, 0);
        drain();
        send(0, 0, 7'h03, 8'h77, 16'h0677, 8'h00);
        drive(0, 0, 0, 0, 0);
        for (int t = 0; t < 2000 && !(sclk[0] && sl[0].n == 5); t++) @(negedge clk);
        chk("reach_5th_high", sclk[0] && sl[0].n == 5, 1);
        #2 rst_n = 1'b0;
        #1;
        chk("abort_cs", cs[0], 1);
        chk("abort_sclk", sclk[0], 0);
        chk("abort_busy", b0.busy, 0);
        chk("abort_ready", b0.req_ready, 1);
        q0.delete();
        last_rd[0] = 8'h00;
        @(negedge clk);
        rst_n = 1'b1;
        s_rsp = rsp0;
        repeat (200) @(negedge clk);
        chk("abort_no_rsp", rsp0 - s_rsp, 0);
        send(0, 1, 7'h03, 8'h00, 16'h0700, 8'h55);
        drive(0, 0, 0, 0, 0);
        drain();
        s_rsp = rsp0;
        send(0, 0, 7'h05, 8'h81, 16'h0A81, 8'h00);
        s_acc = acc0;
        for (int t = 0; t < 400 && !b0.req_ready; t++) begin
            if (t == 50) begin
                chk("mid_busy", b0.busy, 1);
                chk("mid_ready", b0.req_ready, 0);
            end
            drive(0, t[0], t[1], 7'(t), 8'(t));
            @(negedge clk);
        end
        drive(0, 0, 0, 0, 0);
        chk("no_accept_while_busy", acc0 - s_acc, 0);
        drain();
        chk("one_rsp_per_accept", rsp0 - s_rsp, 1);
        send(0, 1, 7'h05, 8'h00, 16'h0B00, 8'h81);
        drive(0, 0, 0, 0, 0);
        drain();
        send(1, 0, 7'h7F, 8'hFF, 16'hFEFF, 8'h00);
        drive(1, 0, 0, 0, 0);
        drain();
        send(1, 1, 7'h7F, 8'h00, 16'hFF00, 8'hFF);
        drive(1, 0, 0, 0, 0);
        drain();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
